rc_pulse_transmitter: RTL and testbench

RC_PULSE_TRANSMITTER -- requirements
Module: rc_pulse_transmitter

---
 rtl/rc_tx_pkg.sv | 18 +
 rtl/rc_pulse_transmitter_if.sv | 9 +
 rtl/rc_us_timebase.sv | 37 +++
 rtl/rc_pulse_transmitter.sv | 82 ++++++++
 tb/tb_rc_pulse_transmitter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rc_tx_pkg.sv
// Shared constants and types for the RC servo pulse transmitter.
// Pulse widths are kept in whole microseconds and scaled to clock ticks by the timebase.
package rc_tx_pkg;
  localparam int FRAME_US     = 20000;
  localparam int MIN_PULSE_US = 1000;
  localparam int US_PER_LSB   = 4;
  localparam int NUM_CH       = 4;
  localparam int US_CNT_W     = 15;

  typedef logic [10:0]         pulse_us_t;
  typedef logic [US_CNT_W-1:0] us_cnt_t;
  typedef logic [7:0]          ch_val_t;

  // 1000 + 4*v tops out at 2020 us, which fits in 11 bits with no overflow
  function automatic pulse_us_t pulse_width(input ch_val_t v);
    return pulse_us_t'(MIN_PULSE_US) + pulse_us_t'(v) * pulse_us_t'(US_PER_LSB);
  endfunction
endpackage

// File: rtl/rc_pulse_transmitter_if.sv
// Command handshake between the flight controller and the pulse transmitter.
interface rc_pulse_transmitter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/rc_us_timebase.sv
// Microsecond prescaler and 20 ms frame counter; both held at zero while disabled
// so the first enabled cycle is always a frame boundary.
module rc_us_timebase
  import rc_tx_pkg::*;
#(
  parameter int TICKS_PER_US = 12
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enable,
  output logic    us_tick,
  output us_cnt_t us_cnt,
  output logic    boundary
);
  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_US - 1);
  localparam us_cnt_t    US_MAX    = us_cnt_t'(FRAME_US - 1);

  logic [7:0] presc;

  assign us_tick  = enable && (presc == PRESC_MAX);
  assign boundary = enable && (presc == '0) && (us_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (!enable) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (us_tick) begin
      presc  <= '0;
      us_cnt <= (us_cnt == US_MAX) ? '0 : us_cnt + 1'b1;
    end else begin
      presc  <= presc + 1'b1;
    end
  end
endmodule

// File: rtl/rc_pulse_transmitter.sv
// Four-channel RC servo PWM generator with a one-deep command staging buffer
// that is committed to the active widths only at frame boundaries.
module rc_pulse_transmitter
  import rc_tx_pkg::*;
#(
  parameter int TICKS_PER_US = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  rc_pulse_transmitter_if.slave   cmd,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_start
);
  us_cnt_t us_cnt;
  logic    us_tick;
  logic    boundary;
  logic    unused_tick;

  rc_us_timebase #(.TICKS_PER_US(TICKS_PER_US)) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .us_tick  (us_tick),
    .us_cnt   (us_cnt),
    .boundary (boundary)
  );
  assign unused_tick = us_tick;

  logic [NUM_CH-1:0][7:0] staging;
  logic [NUM_CH-1:0][7:0] active;
  logic [NUM_CH-1:0][7:0] active_nxt;
  logic                   staged_full;
  logic                   accept;
  logic                   load;
  logic [NUM_CH-1:0]      pwm_nxt;

  assign cmd.cmd_ready = ~staged_full;
  assign accept        = cmd.cmd_valid & ~staged_full;
  // accept needs an empty buffer and load a full one, so a command taken in the
  // boundary cycle waits in staging for the next frame
  assign load          = boundary & staged_full;
  assign active_nxt    = load ? staging : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging     <= '0;
      staged_full <= 1'b0;
      active      <= '0;
    end else begin
      if (accept) begin
        staging     <= cmd.cmd_data;
        staged_full <= 1'b1;
      end else if (load) begin
        staged_full <= 1'b0;
      end
      active <= active_nxt;
    end
  end

  // Compare against active_nxt so the boundary cycle already sees the new width
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pulse_us_t width;
    assign width      = pulse_width(active_nxt[k]);
    assign pwm_nxt[k] = enable && (us_cnt < us_cnt_t'(width));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      pwm_out     <= pwm_nxt;
      frame_start <= boundary;
    end
  end

  a_fs_single: assert property (@(posedge clk) disable iff (!rst_n)
    frame_start |=> !frame_start);
  a_off_low: assert property (@(posedge clk) disable iff (!rst_n)
    !enable |=> (pwm_out == '0) && !frame_start);
endmodule

// File: tb/tb_rc_pulse_transmitter.sv
// Directed bench for rc_pulse_transmitter at 2 clocks per microsecond.
module tb_rc_pulse_transmitter;
  localparam int T = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] pwm_out;
  logic       frame_start;
  int         n_cmp = 0;
  int         n_bad = 0;

  rc_pulse_transmitter_if cmd_if ();

  rc_pulse_transmitter #(.TICKS_PER_US(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cmd         (cmd_if),
    .pwm_out     (pwm_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Counts high cycles per channel from the current (frame_start) negedge
  // until every channel is low; also returns cmd_ready one cycle later.
  task automatic measure(output int w[4], output logic rdy1);
    w    = '{default: 0};
    rdy1 = 1'b1;
    for (int i = 0; i < 4200; i++) begin
      if (i > 0 && pwm_out == 4'b0) break;
      for (int k = 0; k < 4; k++) if (pwm_out[k]) w[k]++;
      if (i == 1) rdy1 = cmd_if.cmd_ready;
      @(negedge clk);
    end
  endtask

  // Forces a frame boundary: one disabled cycle, then enable; returns on the
  // negedge where frame_start is expected high.
  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm_out !== 4'h0) begin n_bad++; $display("FAIL reset_pwm: got %h expected 0", pwm_out); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (pwm_out !== 4'h0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL disabled_idle: got pwm=%h fs=%b expected 0/0", pwm_out, frame_start); end
  endtask

  // Full first frame with no prior command; a command is injected mid-pulse
  // and must not disturb this frame.
  task automatic test_idle_frame();
    int w[4];
    int period;
    w = '{default: 0};
    period = 0;
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1 || pwm_out !== 4'hF) begin n_bad++; $display("FAIL first_frame_start: got fs=%b pwm=%h expected 1/f", frame_start, pwm_out); end
    for (int i = 0; i < 40100; i++) begin
      if (i > 0 && frame_start) begin period = i; break; end
      for (int k = 0; k < 4; k++) if (pwm_out[k]) w[k]++;
      if (i == 500) begin cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 32'hFF800100; end
      if (i == 501) begin
        cmd_if.cmd_valid = 1'b0;
        n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL midframe_accept: got ready=%b expected 0", cmd_if.cmd_ready); end
      end
      @(negedge clk);
    end
    n_cmp++; if (period !== 40000) begin n_bad++; $display("FAIL frame_period: got %0d expected 40000", period); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2000) begin n_bad++; $display("FAIL idle_width ch%0d: got %0d expected 2000", k, w[k]); end
    end
  endtask

  task automatic test_midframe_cmd();
    int   w[4];
    int   exp_w[4];
    logic r;
    exp_w = '{2000, 2008, 3024, 4040};
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== exp_w[k]) begin n_bad++; $display("FAIL cmd_width ch%0d: got %0d expected %0d", k, w[k], exp_w[k]); end
    end
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL staging_cleared: got ready=%b expected 1", r); end
  endtask

  task automatic test_back_to_back();
    int   w[4];
    logic r;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 32'h10101010;
    @(negedge clk);
    n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first_accept: got ready=%b expected 0", cmd_if.cmd_ready); end
    cmd_if.cmd_data = 32'h20202020;
    repeat (5) @(negedge clk);
    n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got ready=%b expected 0", cmd_if.cmd_ready); end
    restart();
    n_cmp++; if (frame_start !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_boundary: got fs=%b ready=%b expected 1/1", frame_start, cmd_if.cmd_ready); end
    measure(w, r);
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: got ready=%b expected 0", r); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2128) begin n_bad++; $display("FAIL b2b_first_width ch%0d: got %0d expected 2128", k, w[k]); end
    end
    restart();
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL b2b_fs2: got %b expected 1", frame_start); end
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2256) begin n_bad++; $display("FAIL b2b_second_width ch%0d: got %0d expected 2256", k, w[k]); end
    end
  endtask

  task automatic test_enable_drop();
    int   w[4];
    logic r;
    restart();
    repeat (50) @(negedge clk);
    n_cmp++; if (pwm_out !== 4'hF) begin n_bad++; $display("FAIL drop_midpulse: got %h expected f", pwm_out); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (pwm_out !== 4'h0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL drop_next_cycle: got pwm=%h fs=%b expected 0/0", pwm_out, frame_start); end
    repeat (10) @(negedge clk);
    n_cmp++; if (pwm_out !== 4'h0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL drop_hold: got pwm=%h fs=%b expected 0/0", pwm_out, frame_start); end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1 || pwm_out !== 4'hF) begin n_bad++; $display("FAIL reenable: got fs=%b pwm=%h expected 1/f", frame_start, pwm_out); end
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2256) begin n_bad++; $display("FAIL reenable_width ch%0d: got %0d expected 2256", k, w[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int   w[4];
    logic r;
    restart();
    repeat (20) @(negedge clk);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 32'hFFFFFFFF;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (cmd_if.cmd_ready !== 1'b0 || pwm_out !== 4'hF) begin n_bad++; $display("FAIL pre_reset: got ready=%b pwm=%h expected 0/f", cmd_if.cmd_ready, pwm_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm_out !== 4'h0 || frame_start !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset: got pwm=%h fs=%b ready=%b expected 0/0/1", pwm_out, frame_start, cmd_if.cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1 || pwm_out !== 4'hF) begin n_bad++; $display("FAIL post_reset_frame: got fs=%b pwm=%h expected 1/f", frame_start, pwm_out); end
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2000) begin n_bad++; $display("FAIL post_reset_width ch%0d: got %0d expected 2000", k, w[k]); end
    end
  endtask

  task automatic test_boundary_accept();
    int   w[4];
    int   exp_w[4];
    logic r;
    exp_w = '{2128, 2256, 2384, 2512};
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1; cmd_if.cmd_valid = 1'b1; cmd_if.cmd_data = 32'h40302010;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (frame_start !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL boundary_accept: got fs=%b ready=%b expected 1/0", frame_start, cmd_if.cmd_ready); end
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== 2000) begin n_bad++; $display("FAIL boundary_same_frame ch%0d: got %0d expected 2000", k, w[k]); end
    end
    restart();
    measure(w, r);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (w[k] !== exp_w[k]) begin n_bad++; $display("FAIL boundary_next_frame ch%0d: got %0d expected %0d", k, w[k], exp_w[k]); end
    end
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL boundary_ready: got %b expected 1", r); end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    test_reset();
    test_idle_frame();
    test_midframe_cmd();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_boundary_accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
